// File: rtl/region_stream_reader.sv
// -----------------------------------------------------------------------------
// region_stream_reader
//
// Read-side master for a fifobram region channel. A command picks the BRAM or
// FIFO region, a start address and a line count. The block issues
// credit-limited reads and parks returned lines in a small skid FIFO. It hands
// the lines downstream as an in-order valid/ready stream.
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   start            one-cycle command strobe (honoured only when idle)
//   start_fifobram   region select: 2'b01 = BRAM, 2'b10 = FIFO
//   start_addr       first BRAM address (ignored by a FIFO region)
//   num_lines        number of lines to read (32 bit, 0 = empty command)
//   re, raddr        region read enable / address
//   rfifobram        region select presented to the region
//   rvalid, rdata    region read response (one cycle after re)
//   empty            FIFO-region empty flag
//   out_valid/_data  stream output, out_ready is the downstream accept
//   busy             high whenever the block is not idle
//   done             one-cycle completion pulse
//   stall_cycles     cycles with out_valid && !out_ready since the last start
//
// Optional build macro: REGION_READER_STATS_EN
//   defined   -> stall_cycles is a live saturating counter
//   undefined -> stall_cycles is tied to zero, no counter is built
// -----------------------------------------------------------------------------
module region_stream_reader #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 5,
    parameter int LOG2_SKID  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            start_fifobram,
    input  logic [LOG2_DEPTH-1:0] start_addr,
    input  logic [31:0]           num_lines,
    output logic                  re,
    output logic [LOG2_DEPTH-1:0] raddr,
    output logic [1:0]            rfifobram,
    input  logic                  rvalid,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  empty,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cycles
);

    localparam int SKID_DEPTH = 1 << LOG2_SKID;
    localparam logic [1:0] MODE_BRAM = 2'b01;
    localparam logic [1:0] MODE_FIFO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [LOG2_DEPTH-1:0]   raddr_q, raddr_d;
    logic [31:0]             issued_q, issued_d;
    logic [31:0]             received_q, received_d;
    logic [31:0]             lines_q, lines_d;
    logic                    inflight_q;

    logic [WIDTH-1:0]        skid_mem_q [SKID_DEPTH];
    logic [LOG2_SKID-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LOG2_SKID-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LOG2_SKID:0]      count_q, count_d;

    logic                    start_ok_s;
    logic                    cmd_valid_s;
    logic [LOG2_SKID+1:0]    occupancy_s;
    logic                    credit_ok_s;
    logic                    re_s;
    logic                    last_issue_s;
    logic                    reading_s;
    logic                    push_s;
    logic                    pop_s;

    // Command acceptance and read-issue qualification.
    always_comb begin
        start_ok_s   = start && (state_q == S_IDLE);
        cmd_valid_s  = (num_lines != 32'd0) &&
                       ((start_fifobram == MODE_BRAM) || (start_fifobram == MODE_FIFO));
        // The read issued last cycle has not landed yet, so it still holds a slot.
        occupancy_s  = {1'b0, count_q} + {{(LOG2_SKID+1){1'b0}}, inflight_q};
        credit_ok_s  = occupancy_s < (LOG2_SKID+2)'(SKID_DEPTH);
        re_s         = (state_q == S_READ) && credit_ok_s && (issued_q < lines_q) &&
                       ((mode_q != MODE_FIFO) || !empty);
        last_issue_s = (issued_q + 32'd1) == lines_q;
        reading_s    = (state_q == S_READ) || (state_q == S_DRAIN);
        // A response is only taken while a read is outstanding; strays are dropped.
        push_s       = rvalid && reading_s && (received_q != issued_q);
        pop_s        = (count_q != '0) && out_ready;
    end

    // Next-state logic of the command FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = cmd_valid_s ? S_READ : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (re_s && last_issue_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if ((received_q == lines_q) && (count_q == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command registers, address generator and issue/receive counters.
    always_comb begin
        mode_d     = mode_q;
        raddr_d    = raddr_q;
        issued_d   = issued_q;
        received_d = received_q;
        lines_d    = lines_q;
        if (start_ok_s && cmd_valid_s) begin
            mode_d     = start_fifobram;
            raddr_d    = start_addr;
            issued_d   = 32'd0;
            received_d = 32'd0;
            lines_d    = num_lines;
        end else begin
            if (re_s) begin
                issued_d = issued_q + 32'd1;
                // BRAM addresses wrap naturally at the address width.
                if (mode_q == MODE_BRAM) begin
                    raddr_d = raddr_q + {{(LOG2_DEPTH-1){1'b0}}, 1'b1};
                end else begin
                    raddr_d = raddr_q;
                end
            end else begin
                issued_d = issued_q;
            end
            if (push_s) begin
                received_d = received_q + 32'd1;
            end else begin
                received_d = received_q;
            end
        end
    end

    // Skid FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + {{(LOG2_SKID-1){1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + {{(LOG2_SKID-1){1'b0}}, 1'b1} : rd_ptr_q;
        if (push_s && !pop_s) begin
            count_d = count_q + (LOG2_SKID+1)'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - (LOG2_SKID+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Control and counter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            raddr_q    <= '0;
            issued_q   <= 32'd0;
            received_q <= 32'd0;
            lines_q    <= 32'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            raddr_q    <= raddr_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            lines_q    <= lines_d;
            inflight_q <= re_s;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Skid FIFO storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            skid_mem_q[wr_ptr_q] <= rdata;
        end
    end

`ifdef REGION_READER_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Saturating backpressure counter, restarted by every accepted command.
    always_comb begin
        stall_d = stall_q;
        if (start_ok_s) begin
            stall_d = 32'd0;
        end else if ((count_q != '0) && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Backpressure counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

    // re must react to the current empty flag, so it is the one combinational output.
    assign re        = re_s;
    assign raddr     = raddr_q;
    assign rfifobram = ((state_q == S_READ) || (state_q == S_DRAIN)) ? mode_q : 2'b00;
    assign out_valid = (count_q != '0);
    assign out_data  = skid_mem_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
